// File: rtl/dmem_wait_ctrl_pkg.sv
// Shared definitions for the data- and instruction-side wait-state memory controllers.
package dmem_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wait_state_t;

  localparam int DEF_LATENCY    = 4;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int CNT_WIDTH      = 4;

endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous word array with write enable and a registered read port.
module ram_sp_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (en && wen) begin
      r_mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (en && !wen) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory slave that stalls the core for LATENCY cycles per access, then pulses ack.
module dmem_wait_ctrl
  import dmem_wait_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        ack
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

  wait_state_t           r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_din;
  logic                  r_is_wr;
  logic                  r_ack;

  logic                  w_req;
  logic                  w_start;
  logic                  w_fire_idle;
  logic                  w_fire_busy;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_din;
  logic                  w_ram_wen;
  logic                  w_unused_addr;

  assign w_req       = ren | we;
  assign w_start     = (r_state == IDLE) && w_req && !rst;
  assign w_fire_busy = (r_state == BUSY) && (r_cnt == CNT_LAST);
  assign w_fire_idle = w_start && (LATENCY == 1);
  assign w_fire      = w_fire_idle | w_fire_busy;

  // With single-cycle latency the access happens on the accept edge, before the latches are valid.
  assign w_ram_addr = w_fire_idle ? addr[ADDR_WIDTH-1:0] : r_addr;
  assign w_ram_din  = w_fire_idle ? din : r_din;
  assign w_ram_wen  = w_fire_idle ? we : r_is_wr;

  assign w_unused_addr = ^addr[31:ADDR_WIDTH];

  assign stall = w_start || (r_state == BUSY);
  assign ack   = r_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_is_wr <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= addr[ADDR_WIDTH-1:0];
            r_din   <= din;
            r_is_wr <= we;
            r_cnt   <= CNT_LOAD;
            if (LATENCY == 1) begin
              r_state <= DONE;
              r_ack   <= 1'b1;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_LAST;
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  ram_sp_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(32)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (w_fire),
    .wen   (w_ram_wen),
    .addr  (w_ram_addr),
    .wdata (w_ram_din),
    .rdata (dout)
  );

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Randomised and directed bench for dmem_wait_ctrl at LATENCY=4 and LATENCY=1 against a behavioural model.
module tb_dmem_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        stall [2];
  logic        ack   [2];

  int          n_checks = 0;
  int          n_errors = 0;

  // Behavioural model: word array per instance plus the last read value.
  logic [31:0] m_mem        [2][1024];
  bit          m_valid      [2][1024];
  logic [31:0] m_dout       [2];
  bit          m_dout_known [2];
  int          lat          [2];
  time         last_ack_t   [2];

  always #5 clk = ~clk;

  dmem_wait_ctrl #(.ADDR_WIDTH(10), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .ren(ren[0]), .we(we[0]), .addr(addr[0]), .din(din[0]),
    .dout(dout[0]), .stall(stall[0]), .ack(ack[0])
  );

  dmem_wait_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ren(ren[1]), .we(we[1]), .addr(addr[1]), .din(din[1]),
    .dout(dout[1]), .stall(stall[1]), .ack(ack[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input int d, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input bit scramble);
    int       nst;
    int       ack_cycle;
    bit       got_ack;
    logic [9:0] idx;
    idx       = a[9:0];
    nst       = 0;
    ack_cycle = -1;
    got_ack   = 1'b0;
    @(negedge clk);
    ren[d] = rd; we[d] = wr; addr[d] = a; din[d] = wd;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (ack[d] === 1'b1) begin
        got_ack   = 1'b1;
        ack_cycle = c;
        break;
      end
      if (stall[d] === 1'b1) nst++;
      @(negedge clk);
      if (!hold) begin
        ren[d] = 1'b0;
        we[d]  = 1'b0;
      end
      if (scramble) begin
        addr[d] = $urandom;
        din[d]  = $urandom;
      end
    end
    if (wr) begin
      m_mem[d][idx]   = wd;
      m_valid[d][idx] = 1'b1;
    end else if (rd) begin
      m_dout_known[d] = m_valid[d][idx];
      m_dout[d]       = m_mem[d][idx];
    end
    chk("ack_seen", 32'(got_ack), 32'd1);
    chk("ack_latency", ack_cycle, lat[d]);
    chk("stall_cycles", nst, lat[d]);
    if (m_dout_known[d]) chk("dout", dout[d], m_dout[d]);
    last_ack_t[d] = $time;
    $display("TXN dut%0d wr=%0d rd=%0d addr=%h wdata=%h dout=%h stall=%0d ack_at=%0d",
             d, wr, rd, a, wd, dout[d], nst, ack_cycle);
    if (!hold) begin
      @(negedge clk);
      #1;
      chk("ack_one_cycle", 32'(ack[d]), 32'd0);
      chk("idle_no_stall", 32'(stall[d]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1;
    lat[0] = 4;
    lat[1] = 1;
    for (int d = 0; d < 2; d++) begin
      ren[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; din[d] = '0;
      m_dout[d] = '0; m_dout_known[d] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_dout", dout[d], 32'd0);
      chk("rst_stall", 32'(stall[d]), 32'd0);
      chk("rst_ack", 32'(ack[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Write then reset in the middle of an overwrite; the first value must survive.
    access(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'h10; din[0] = 32'h12345678;
    @(negedge clk);
    we[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1; we[0] = 1'b1; ren[1] = 1'b1;
    #1;
    chk("midbusy_rst_stall", 32'(stall[0]), 32'd0);
    chk("midbusy_rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_req_stall1", 32'(stall[1]), 32'd0);
    @(negedge clk);
    we[0] = 1'b0; ren[1] = 1'b0; rst = 1'b0;
    for (int d = 0; d < 2; d++) m_dout[d] = '0;

    access(0, 0, 1, 32'h10, 32'h0, 0, 0);
    chk("reread_after_rst", dout[0], 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("dout_hold", dout[0], 32'hDEADBEEF);
    end

    // ren and we together behave as a write.
    access(0, 1, 1, 32'h7, 32'h55, 0, 0);
    chk("both_dout_kept", dout[0], 32'hDEADBEEF);
    access(0, 0, 1, 32'h7, 32'h0, 0, 0);

    // Upper address bits alias onto the low index.
    access(0, 1, 0, 32'h00000405, 32'hCAFEF00D, 0, 0);
    access(0, 0, 1, 32'h005, 32'h0, 0, 0);
    chk("alias_read", dout[0], 32'hCAFEF00D);

    // Read held across the ack cycle: second access starts in the next IDLE cycle.
    access(0, 0, 1, 32'h10, 32'h0, 1, 0);
    t1 = last_ack_t[0];
    access(0, 0, 1, 32'h10, 32'h0, 0, 0);
    chk("b2b_ack_gap", int'((last_ack_t[0] - t1) / 10), lat[0] + 1);

    // Inputs scrambled while busy must not affect the latched request.
    access(0, 0, 1, 32'h7, 32'h0, 0, 1);
    chk("scramble_read", dout[0], 32'h55);

    access(1, 1, 0, 32'h3, 32'h0000A5A5, 0, 0);
    access(1, 0, 1, 32'h3, 32'h0, 0, 0);
    chk("lat1_read", dout[1], 32'h0000A5A5);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        logic [31:0] ra;
        int          op;
        ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
        op = $urandom_range(0, 5);
        if (op < 2)       access(d, 1, 0, ra, $urandom, 0, $urandom_range(0, 1) == 1);
        else if (op == 2) access(d, 1, 1, ra, $urandom, 0, $urandom_range(0, 1) == 1);
        else              access(d, 0, 1, ra, 32'h0, 0, $urandom_range(0, 1) == 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Multi-cycle data-memory slave sitting directly downstream of the core's MEM stage.
- Accepts word-addressed read/write requests and holds the core with `stall` for a fixed, parameterised access latency.
- Pulses `ack` on completion and presents read data.
- Models a slow external RAM so the pipeline's memory-stall path can be exercised; it replaces a zero-wait data memory at the same place in the CPU top.

Parameters:
- ADDR_WIDTH, 10, index bits of internal word array; depth = 2^ADDR_WIDTH words of 32 bits.
- LATENCY, 4, total stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  main clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ren  in  1  read request from core.
- we  in  1  write request from core.
- addr  in  32  word address (core already drops byte offset); only addr[ADDR_WIDTH-1:0] used, upper bits ignored (aliasing).
- din  in  32  write data.
- dout  out  32  read data, registered.
- stall  out  1  core must freeze while high.
- ack  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time): state=IDLE, counter=0, dout=0, ack=0, latched request cleared.
  - Memory array contents are NOT cleared.
  - An in-flight write is discarded.
  - stall=0 while rst high.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If ren|we: stall=1 combinationally in the same cycle.
  - At the clock edge, latch addr, din and op, load counter=LATENCY-1.
  - Next state is BUSY if LATENCY>1, else DONE.
  - With no request: stall=0, stay IDLE.
- BUSY:
  - stall=1.
  - Counter decrements each edge.
  - When counter==1 at the edge, go to DONE and perform the access on that edge:
    - write: mem[idx] <= latched din;
    - read: dout <= mem[idx].
  - For LATENCY=1 the access is performed on the IDLE->DONE edge.
- DONE:
  - stall=0, ack=1 for exactly one cycle; next state is IDLE unconditionally.
  - Request inputs are ignored in DONE; the pipeline advances on this edge, so any request seen in the following IDLE cycle is a new one.
- Stall timing: stall is high for exactly LATENCY consecutive cycles per access; ack follows in the cycle after the last stall cycle. Access-to-ack = LATENCY+1 cycles.
- dout holds its value until the next completed read. Writes never change dout.
- ren and we both high: treated as a write; no read is performed and dout is unchanged.
- Input changes while BUSY are ignored, because the latched copies are used.
- Back-to-back requests: at most one access per LATENCY+1 cycles; no request queueing.
- Counter width: 4 bits. Compare-to-1 termination, no wrap.

Decomposition:
- Shared package / header: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), default LATENCY and ADDR_WIDTH constants. These are shared with the instruction-side wait controller.
- One sub-module: `ram_sp_array`, a single-port synchronous 32-bit word array with write-enable and registered read.
  - It is instantiated once.
  - The controller drives its enables only on the completion edge.

Test Plan:
- Reset mid-BUSY, then reread:
  - Write 0xDEADBEEF to addr 0x10 with LATENCY=4; expect stall high 4 cycles, ack on cycle 5.
  - Then assert rst during BUSY of a write of 0x12345678 to 0x10; expect stall/ack=0 immediately.
  - Read of 0x10 afterwards returns 0xDEADBEEF.
- Read of addr 0x10 after the write: dout=0xDEADBEEF in the ack cycle and held through 3 idle cycles.
- LATENCY=1:
  - Write 0x0000A5A5 to addr 3; expect stall for exactly 1 cycle, then ack.
  - Read addr 3 returns 0x0000A5A5.
- ren=we=1, addr 7, din 0x55:
  - mem[7]=0x55 afterwards.
  - dout keeps its prior value (0xDEADBEEF).
  - ack pulses once.
- Aliasing: write 0xCAFEF00D to addr 0x00000405 with ADDR_WIDTH=10; a read of addr 0x005 returns 0xCAFEF00D.
- Back-to-back and mid-access input changes:
  - Read request held high across the ack cycle; expect a second access to start only in the IDLE cycle after DONE.
  - Expect 2 distinct ack pulses separated by LATENCY+1 cycles.
  - Changing addr during BUSY does not affect the result.
